// File: rtl/intc_pkg.sv
// Shared types and default sizing for the interrupt request controller.
package intc_pkg;

  localparam int unsigned NSrcDefault = 8;
  localparam int unsigned VecWDefault = 4;

  // Encoding stays fixed whether or not the NMI path is built.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StVec  = 2'd2,
    StNreq = 2'd3
  } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module intc_prio_enc #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned VEC_W = 4
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [VEC_W-1:0] idx
);

  // Scan from the top so the last hit, the lowest index, is the one kept.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc_request_controller.sv
// Interrupt request controller: edge-captures peripheral requests into a pending
// register, arbitrates unmasked requests by fixed priority and runs the INT/INA/INTD
// handshake with the processor. Define INTC_NMI_EN to build the non-maskable path;
// without it nmi_src is ignored and NMI stays low.
module intc_request_controller
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = NSrcDefault,
  parameter int unsigned VEC_W = VecWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             nmi_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             INA,
  output logic             INT,
  output logic             NMI,
  output logic             INTD,
  output logic [VEC_W-1:0] vec,
  output logic [N_SRC-1:0] pending
);

  intc_state_e      state_q, state_d;
  logic [N_SRC-1:0] src_q, mask_q, pending_q, pending_d, rise, clr;
  logic [VEC_W-1:0] sel_q, sel_d, win_idx, vec_q;
  logic             win_any, nmi_clr, nmi_pend_q, nmi_pend_d;
  logic             int_q, nmi_q, intd_q;

  assign rise = irq_src & ~src_q;

  intc_prio_enc #(
    .N_SRC(N_SRC),
    .VEC_W(VEC_W)
  ) u_prio_enc (
    .req(pending_q & ~mask_q),
    .any(win_any),
    .idx(win_idx)
  );

`ifdef INTC_NMI_EN
  logic nmi_src_q;

  // NMI edge register; a fresh edge in the clearing cycle keeps the request pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_src_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_src_q  <= nmi_src;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign nmi_pend_d = (nmi_pend_q & ~nmi_clr) | (nmi_src & ~nmi_src_q);
`else
  logic unused_nmi;

  assign nmi_pend_q = 1'b0;
  assign nmi_pend_d = 1'b0;
  assign unused_nmi = nmi_src ^ nmi_clr ^ nmi_pend_d;
`endif

  // Next state, winner latch and pending clear for the handshake.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    clr     = '0;
    nmi_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (nmi_pend_q) begin
          state_d = StNreq;
        end else if (win_any) begin
          state_d = StReq;
          sel_d   = win_idx;
        end
      end
      StReq: begin
        if (INA) begin
          state_d = StVec;
          clr     = N_SRC'(1) << sel_q;
        end
      end
      StVec: state_d = StIdle;
      StNreq: begin
        if (INA) begin
          state_d = StIdle;
          nmi_clr = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Set beats clear, so an edge arriving as its bit is serviced is not lost.
  assign pending_d = (pending_q & ~clr) | rise;

  // State, request capture and registered processor-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      src_q     <= '0;
      mask_q    <= '0;
      pending_q <= '0;
      int_q     <= 1'b0;
      nmi_q     <= 1'b0;
      intd_q    <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      src_q     <= irq_src;
      pending_q <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      int_q  <= (state_d == StReq);
      nmi_q  <= (state_d == StNreq);
      intd_q <= (state_d == StVec);
      vec_q  <= (state_d == StVec) ? sel_d : '0;
    end
  end

  assign INT     = int_q;
  assign NMI     = nmi_q;
  assign INTD    = intd_q;
  assign vec     = vec_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_intc_request_controller.sv
// Directed bench for intc_request_controller with a vector scoreboard.
module tb_intc_request_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_src;
  logic       nmi_src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       INA;
  logic       INT;
  logic       NMI;
  logic       INTD;
  logic [3:0] vec;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int svc_cnt = 0;
  int intd_cnt = 0;
  int both_cnt = 0;

  intc_request_controller #(
    .N_SRC(8),
    .VEC_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_src(irq_src),
    .nmi_src(nmi_src),
    .mask_we(mask_we),
    .mask_wdata(mask_wdata),
    .INA(INA),
    .INT(INT),
    .NMI(NMI),
    .INTD(INTD),
    .vec(vec),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Count vector pulses and any overlap of INT with NMI.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (INTD === 1'b1) intd_cnt++;
      if (INT === 1'b1 && NMI === 1'b1) both_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  // Wait for INT, acknowledge, then compare the vector pulse to the scoreboard.
  task automatic service(input int exp_vec);
    int n = 0;
    while (INT !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("int_before_ack", 32'(INT), 32'd1);
    INA = 1'b1;
    exp_q.push_back(exp_vec);
    svc_cnt++;
    tick();
    INA = 1'b0;
    chk("intd_pulse", 32'(INTD), 32'd1);
    chk("int_low_in_vec", 32'(INT), 32'd0);
    if (exp_q.size() > 0) chk("vec", 32'(vec), 32'(exp_q.pop_front()));
    tick();
    chk("intd_one_cycle", 32'(INTD), 32'd0);
    chk("vec_zero_after", 32'(vec), 32'd0);
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; nmi_src = 1'b0; mask_we = 1'b0; mask_wdata = '0; INA = 1'b0;
    tick();
    tick();
    chk("rst_int", 32'(INT), 32'd0);
    chk("rst_nmi", 32'(NMI), 32'd0);
    chk("rst_intd", 32'(INTD), 32'd0);
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;
    tick();

    // Single source: two-cycle latency, then a re-edge landing on the clear cycle.
    irq_src = 8'h08;
    tick();
    chk("t1_pend", 32'(pending), 32'h08);
    chk("t1_int_early", 32'(INT), 32'd0);
    tick();
    chk("t1_int", 32'(INT), 32'd1);
    irq_src = 8'h00;
    tick();
    tick();
    irq_src = 8'h08;
    service(3);
    chk("t1_set_wins", 32'(pending), 32'h08);
    service(3);
    chk("t1_pend_clr", 32'(pending), 32'h00);
    irq_src = 8'h00;
    tick();

    // Simultaneous sources: lowest index first.
    irq_src = 8'h22;
    tick();
    chk("t2_pend", 32'(pending), 32'h22);
    service(1);
    chk("t2_pend_mid", 32'(pending), 32'h20);
    service(5);
    chk("t2_pend_end", 32'(pending), 32'h00);
    irq_src = 8'h00;

    // Masked source accumulates but does not request; mask while in REQ still completes.
    write_mask(8'h04);
    irq_src = 8'h04;
    tick();
    tick();
    tick();
    chk("t3_int_masked", 32'(INT), 32'd0);
    chk("t3_pend", 32'(pending), 32'h04);
    write_mask(8'h00);
    chk("t3_int_same", 32'(INT), 32'd0);
    tick();
    chk("t3_int_unmask", 32'(INT), 32'd1);
    write_mask(8'h04);
    service(2);
    chk("t3_pend_end", 32'(pending), 32'h00);
    write_mask(8'h00);
    irq_src = 8'h00;
    tick();

`ifdef INTC_NMI_EN
    // NMI arriving during REQ waits for the maskable handshake to finish.
    irq_src = 8'h40;
    tick();
    tick();
    chk("t4_int", 32'(INT), 32'd1);
    irq_src = 8'h00;
    tick();
    irq_src = 8'h40;
    nmi_src = 1'b1;
    tick();
    chk("t4_nmi_held", 32'(NMI), 32'd0);
    service(6);
    tick();
    chk("t4_nmi", 32'(NMI), 32'd1);
    chk("t4_nmi_int", 32'(INT), 32'd0);
    chk("t4_nmi_intd", 32'(INTD), 32'd0);
    INA = 1'b1;
    tick();
    INA = 1'b0;
    chk("t4_nmi_done", 32'(NMI), 32'd0);
    chk("t4_no_vec", 32'(INTD), 32'd0);
    tick();
    chk("t4_idle", 32'(INT), 32'd0);
    nmi_src = 1'b0;
    irq_src = 8'h00;
    tick();
`else
    // NMI input has no effect when the feature is not built.
    nmi_src = 1'b1;
    tick();
    nmi_src = 1'b0;
    tick();
    tick();
    chk("t5_nmi", 32'(NMI), 32'd0);
    chk("t5_int", 32'(INT), 32'd0);
    irq_src = 8'h10;
    service(4);
    irq_src = 8'h00;
    tick();
`endif

    // Reset mid-handshake abandons it; INA in IDLE is ignored.
    irq_src = 8'h01;
    tick();
    tick();
    chk("t6_int", 32'(INT), 32'd1);
    rst = 1'b1;
    irq_src = 8'h00;
    tick();
    rst = 1'b0;
    chk("t6_int_rst", 32'(INT), 32'd0);
    chk("t6_pend_rst", 32'(pending), 32'h00);
    chk("t6_intd_rst", 32'(INTD), 32'd0);
    INA = 1'b1;
    tick();
    tick();
    INA = 1'b0;
    chk("t6_ina_idle_int", 32'(INT), 32'd0);
    chk("t6_ina_idle_intd", 32'(INTD), 32'd0);
    tick();
    tick();

    chk("intd_count", 32'(intd_cnt), 32'(svc_cnt));
    chk("int_nmi_overlap", 32'(both_cnt), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
